// File: rtl/ulaw_pkg.sv
// Shared types and widths for the channel-arbitrated u-law compressor.
package ulaw_pkg;

  localparam int SAMPLE_W = 14;
  localparam int CODE_W   = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    ENC   = 2'd2,
    OUT   = 2'd3
  } state_t;

endpackage

// File: rtl/ulaw_chan_arb_if.sv
// Channel request/ack bus plus the downstream code valid/ready bus.
interface ulaw_chan_arb_if
  import ulaw_pkg::*;
#(
  parameter int NCH = 4,
  parameter int CW  = $clog2(NCH)
);

  logic [NCH-1:0]          req;
  logic [SAMPLE_W*NCH-1:0] in_data;
  logic [NCH-1:0]          ack;
  logic [CODE_W-1:0]       out_code;
  logic [CW-1:0]           out_chan;
  logic                    out_valid;
  logic                    out_ready;
  logic                    busy;

  modport master (
    output req, in_data, out_ready,
    input  ack, out_code, out_chan, out_valid, busy
  );

  modport slave (
    input  req, in_data, out_ready,
    output ack, out_code, out_chan, out_valid, busy
  );

endinterface

// File: rtl/ulaw_comp.sv
// Combinational 14-bit to 8-bit u-law compressor; the clock port exists only
// for pin compatibility with the block it replaces.
module ulaw_comp
  import ulaw_pkg::*;
(
  input  logic                clk,
  input  logic [SAMPLE_W-1:0] sample,
  output logic [CODE_W-1:0]   code
);

  logic [2:0] seg;
  logic [3:0] mant;
  logic       found;
  logic       unused_bits;

  // Bit 0 never reaches the mantissa, even for the lowest segment.
  assign unused_bits = clk ^ sample[0];

  always_comb begin
    seg   = '0;
    mant  = '0;
    found = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      if (!found && sample[i+5]) begin
        found = 1'b1;
        seg   = 3'(i);
        mant  = sample[i+1 +: 4];
      end
    end
  end

  assign code = {sample[SAMPLE_W-1], seg, mant};

endmodule

// File: rtl/ulaw_chan_arb.sv
// Round-robin time-sharing of one u-law compressor among NCH sample channels,
// with a registered valid/ready output toward the framer.
module ulaw_chan_arb
  import ulaw_pkg::*;
#(
  parameter int NCH = 4,
  parameter int CW  = $clog2(NCH)
) (
  input  logic            clk,
  input  logic            rst,
  ulaw_chan_arb_if.slave  bus
);

  localparam logic [1:0] ST_IDLE  = IDLE;
  localparam logic [1:0] ST_GRANT = GRANT;
  localparam logic [1:0] ST_ENC   = ENC;
  localparam logic [1:0] ST_OUT   = OUT;

  logic [1:0]          state_reg;
  logic [CW-1:0]       ptr_reg;
  logic [CW-1:0]       chan_reg;
  logic [SAMPLE_W-1:0] sample_reg;
  logic [NCH-1:0]      ack_reg;
  logic [CODE_W-1:0]   code_reg;
  logic [CW-1:0]       out_chan_reg;
  logic                valid_reg;

  logic [CW-1:0]       sel;
  logic [CW-1:0]       ptr_next;
  logic [CODE_W-1:0]   comp_code;
  logic [SAMPLE_W-1:0] ch_sample [NCH];

  for (genvar gi = 0; gi < NCH; gi++) begin : g_split
    assign ch_sample[gi] = bus.in_data[SAMPLE_W*gi +: SAMPLE_W];
  end

  // First requester at or after p, wrapping; the reverse scan lets the
  // lowest offset from p win.
  function automatic logic [CW-1:0] rr_select(input logic [NCH-1:0] r,
                                              input logic [CW-1:0]  p);
    logic [CW-1:0] s;
    int            idx;
    s = '0;
    for (int k = NCH - 1; k >= 0; k--) begin
      idx = int'(p) + k;
      if (idx >= NCH) idx = idx - NCH;
      if (r[idx]) s = CW'(idx);
    end
    return s;
  endfunction

  assign sel      = rr_select(bus.req, ptr_reg);
  assign ptr_next = (sel == CW'(NCH - 1)) ? '0 : sel + 1'b1;

  ulaw_comp u_comp (
    .clk    (clk),
    .sample (sample_reg),
    .code   (comp_code)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= ST_IDLE;
      ptr_reg      <= '0;
      chan_reg     <= '0;
      sample_reg   <= '0;
      ack_reg      <= '0;
      code_reg     <= '0;
      out_chan_reg <= '0;
      valid_reg    <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (|bus.req) begin
            sample_reg <= ch_sample[sel];
            chan_reg   <= sel;
            ack_reg    <= {{(NCH-1){1'b0}}, 1'b1} << sel;
            ptr_reg    <= ptr_next;
            state_reg  <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          ack_reg   <= '0;
          state_reg <= ST_ENC;
        end
        ST_ENC: begin
          code_reg     <= comp_code;
          out_chan_reg <= chan_reg;
          valid_reg    <= 1'b1;
          state_reg    <= ST_OUT;
        end
        ST_OUT: begin
          if (bus.out_ready) begin
            valid_reg <= 1'b0;
            state_reg <= ST_IDLE;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign bus.ack       = ack_reg;
  assign bus.out_code  = code_reg;
  assign bus.out_chan  = out_chan_reg;
  assign bus.out_valid = valid_reg;
  assign bus.busy      = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_ulaw_chan_arb.sv
// Self-checking bench for ulaw_chan_arb against a transaction-level model.
module tb_ulaw_chan_arb;
  import ulaw_pkg::*;

  localparam int NCH = 4;

  logic clk;
  logic rst;
  int   checks   = 0;
  int   failures = 0;
  int   mptr     = 0;
  int   txn_no   = 0;

  ulaw_chan_arb_if #(.NCH(NCH)) bus ();

  ulaw_chan_arb #(.NCH(NCH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, got running required finished");
    $fatal(1, "watchdog");
  end

  // u-law by arithmetic: segment from floor(log2(magnitude)).
  function automatic logic [7:0] model_ulaw(input logic [13:0] s);
    int m;
    int p;
    m = int'(s[12:0]);
    if (m < 32) return {s[13], 7'd0};
    p = 0;
    while ((m >> (p + 1)) != 0) p++;
    return {s[13], 3'(p - 5), 4'((m >> (p - 4)) & 15)};
  endfunction

  function automatic int model_sel(input logic [NCH-1:0] r, input int p);
    for (int k = 0; k < NCH; k++)
      if (r[(p + k) % NCH]) return (p + k) % NCH;
    return -1;
  endfunction

  task automatic set_sample(input int ch, input logic [13:0] v);
    bus.in_data[14*ch +: 14] = v;
  endtask

  task automatic do_reset();
    bus.req       = '0;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst  = 1'b0;
    mptr = 0;
  endtask

  // Called at posedge+1 with the DUT in IDLE and req set; returns in IDLE.
  task automatic txn(input int wait_n, input bit drop);
    int          ec;
    logic [7:0]  ecode;
    logic [13:0] s;
    ec = model_sel(bus.req, mptr);
    if (ec < 0) begin
      checks++; failures++;
      $display("FAIL txn_setup: got req=0 required nonzero req");
      return;
    end
    s     = bus.in_data[14*ec +: 14];
    ecode = model_ulaw(s);
    mptr  = (ec + 1) % NCH;
    @(posedge clk); #1;
    checks++;
    if (bus.ack !== 4'(1 << ec)) begin
      failures++;
      $display("FAIL ack_grant: got %b required %b", bus.ack, 4'(1 << ec));
    end
    checks++;
    if (bus.busy !== 1'b1) begin
      failures++;
      $display("FAIL busy_grant: got %b required 1", bus.busy);
    end
    if (drop) bus.req[ec] = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (bus.ack !== 4'b0 || bus.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL enc_quiet: got ack=%b valid=%b required ack=0000 valid=0",
               bus.ack, bus.out_valid);
    end
    @(posedge clk); #1;
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_code !== ecode || bus.out_chan !== 2'(ec)) begin
      failures++;
      $display("FAIL out_word: got valid=%b code=%h chan=%0d required valid=1 code=%h chan=%0d",
               bus.out_valid, bus.out_code, bus.out_chan, ecode, ec);
    end
    bus.out_ready = (wait_n == 0);
    for (int i = 0; i < wait_n; i++) begin
      @(posedge clk); #1;
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_code !== ecode || bus.out_chan !== 2'(ec) ||
          bus.ack !== 4'b0 || bus.busy !== 1'b1) begin
        failures++;
        $display("FAIL out_hold: got valid=%b code=%h chan=%0d ack=%b required valid=1 code=%h chan=%0d ack=0000",
                 bus.out_valid, bus.out_code, bus.out_chan, bus.ack, ecode, ec);
      end
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.ack !== 4'b0) begin
      failures++;
      $display("FAIL back_idle: got valid=%b busy=%b ack=%b required 0 0 0000",
               bus.out_valid, bus.busy, bus.ack);
    end
    txn_no++;
    $display("txn %0d: chan=%0d sample=%h code=%h wait=%0d", txn_no, ec, s, ecode, wait_n);
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (bus.ack !== 4'b0 || bus.out_code !== 8'h00 || bus.out_chan !== 2'd0 ||
        bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: got ack=%b code=%h chan=%0d valid=%b busy=%b required all 0",
               bus.ack, bus.out_code, bus.out_chan, bus.out_valid, bus.busy);
    end
    repeat (3) begin
      @(posedge clk); #1;
      checks++;
      if (bus.ack !== 4'b0 || bus.busy !== 1'b0) begin
        failures++;
        $display("FAIL idle_no_req: got ack=%b busy=%b required 0000 0", bus.ack, bus.busy);
      end
    end
  endtask

  task automatic test_single();
    do_reset();
    set_sample(0, 14'h0100);
    bus.req = 4'b0001;
    txn(0, 1'b1);
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int c = 0; c < NCH; c++) set_sample(c, 14'(16'h0040 << c));
    bus.req = 4'b1111;
    for (int t = 0; t < 8; t++) txn(0, 1'b0);
    bus.req = '0;
  endtask

  task automatic test_encoding();
    logic [13:0] vals [5];
    vals = '{14'h0800, 14'h0000, 14'h2000, 14'h2800, 14'h1FFF};
    do_reset();
    for (int v = 0; v < 5; v++) begin
      set_sample(2, vals[v]);
      bus.req = 4'b0100;
      txn(0, 1'b1);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    set_sample(0, 14'h0555);
    set_sample(1, 14'h2123);
    bus.req = 4'b0011;
    txn(10, 1'b1);
    txn(0, 1'b1);
  endtask

  task automatic test_pointer_skip();
    do_reset();
    set_sample(0, 14'h0033);
    set_sample(3, 14'h0F00);
    bus.req = 4'b0001;
    txn(0, 1'b1);
    bus.req = 4'b1001;
    txn(0, 1'b0);
    txn(0, 1'b0);
    set_sample(1, 14'h0222);
    bus.req = 4'b0011;
    txn(0, 1'b1);
    bus.req = '0;
  endtask

  task automatic test_withdraw();
    do_reset();
    bus.req = 4'b0100;
    #3;
    bus.req = 4'b0000;
    @(posedge clk); #1;
    checks++;
    if (bus.ack !== 4'b0 || bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL withdraw: got ack=%b busy=%b required 0000 0", bus.ack, bus.busy);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    set_sample(2, 14'h1FFF);
    bus.req = 4'b0100;
    @(posedge clk); #1;
    bus.req = 4'b0000;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    checks++;
    if (bus.ack !== 4'b0 || bus.out_code !== 8'h00 || bus.out_chan !== 2'd0 ||
        bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_in_enc: got ack=%b code=%h chan=%0d valid=%b busy=%b required all 0",
               bus.ack, bus.out_code, bus.out_chan, bus.out_valid, bus.busy);
    end
    @(posedge clk); #3;
    rst  = 1'b0;
    mptr = 0;
    repeat (3) begin
      @(posedge clk); #1;
      checks++;
      if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
        failures++;
        $display("FAIL discard: got valid=%b busy=%b required 0 0", bus.out_valid, bus.busy);
      end
    end
    // Reset while a code is waiting in OUT must clear the held word.
    set_sample(3, 14'h1FFF);
    bus.req = 4'b1000;
    repeat (3) @(posedge clk);
    #1;
    bus.req       = 4'b0000;
    bus.out_ready = 1'b0;
    rst = 1'b1;
    #1;
    checks++;
    if (bus.out_code !== 8'h00 || bus.out_chan !== 2'd0 || bus.out_valid !== 1'b0 ||
        bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_in_out: got code=%h chan=%0d valid=%b busy=%b required all 0",
               bus.out_code, bus.out_chan, bus.out_valid, bus.busy);
    end
    @(posedge clk); #3;
    rst = 1'b0;
    bus.out_ready = 1'b1;
    mptr = 0;
    @(posedge clk); #1;
    set_sample(1, 14'h0400);
    set_sample(2, 14'h0080);
    bus.req = 4'b0110;
    txn(0, 1'b1);
    bus.req = '0;
  endtask

  task automatic test_random();
    do_reset();
    for (int t = 0; t < 40; t++) begin
      for (int c = 0; c < NCH; c++) set_sample(c, 14'($urandom));
      bus.req = 4'($urandom_range(1, 15));
      txn(int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) begin
        bus.req = '0;
        @(posedge clk); #1;
        checks++;
        if (bus.ack !== 4'b0 || bus.busy !== 1'b0) begin
          failures++;
          $display("FAIL random_gap: got ack=%b busy=%b required 0000 0", bus.ack, bus.busy);
        end
      end
    end
    bus.req = '0;
  endtask

  initial begin
    rst           = 1'b1;
    bus.req       = '0;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;
    test_reset();
    test_single();
    test_round_robin();
    test_encoding();
    test_backpressure();
    test_pointer_skip();
    test_withdraw();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
